// File: rtl/cache_control.sv
// Sequencing controller for a 2-way set-associative write-back L1 cache.
// It owns the valid/dirty/LRU metadata and runs the pmem line fill and writeback handshake.
module cache_control #(
    parameter int INDEX_W = 3
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [INDEX_W-1:0] index,
    input  logic               mem_read,
    input  logic               mem_write,
    output logic               mem_resp,
    input  logic               tag_match0,
    input  logic               tag_match1,
    input  logic               pmem_resp,
    output logic               pmem_read,
    output logic               pmem_write,
    output logic               data_write0,
    output logic               data_write1,
    output logic               tag_load0,
    output logic               tag_load1,
    output logic               datain_sel,
    output logic               way_sel,
    output logic               pmem_addr_sel
);

    localparam int SETS = 2 ** INDEX_W;

    typedef enum logic [1:0] {
        CHECK     = 2'd0,
        WRITEBACK = 2'd1,
        ALLOCATE  = 2'd2
    } state_t;

    state_t state, state_next;

    // Metadata indexed as [way][set]; lru[set] names the least-recently-used way.
    logic [1:0][SETS-1:0] valid;
    logic [1:0][SETS-1:0] dirty;
    logic [SETS-1:0]      lru;

    logic       req;
    logic       hit0;
    logic       hit1;
    logic       hit;
    logic       hit_way;
    logic       victim;
    logic       victim_dirty;

    // Metadata update strobes produced by the next-state logic.
    logic       set_dirty;
    logic       clr_dirty;
    logic       fill;
    logic       lru_touch;
    logic       lru_way;
    logic [1:0] data_write;
    logic [1:0] tag_load;

    assign req          = mem_read | mem_write;
    assign hit0         = valid[0][index] & tag_match0;
    // Way 0 wins if both ways report a hit.
    assign hit1         = valid[1][index] & tag_match1 & ~hit0;
    assign hit          = hit0 | hit1;
    assign hit_way      = hit1;
    assign victim       = lru[index];
    assign victim_dirty = valid[victim][index] & dirty[victim][index];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= CHECK;
        end else begin
            // NOTE: all clocked state uses non-blocking assignments so every register samples pre-edge values.
            state <= state_next;
        end
    end

    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path can infer a latch.
        state_next    = state;
        mem_resp      = 1'b0;
        pmem_read     = 1'b0;
        pmem_write    = 1'b0;
        data_write    = 2'b00;
        tag_load      = 2'b00;
        datain_sel    = 1'b0;
        way_sel       = 1'b0;
        pmem_addr_sel = 1'b0;
        set_dirty     = 1'b0;
        clr_dirty     = 1'b0;
        fill          = 1'b0;
        lru_touch     = 1'b0;
        lru_way       = 1'b0;

        unique case (state)
            CHECK: begin
                if (req) begin
                    if (hit) begin
                        mem_resp  = 1'b1;
                        way_sel   = hit_way;
                        lru_touch = 1'b1;
                        lru_way   = hit_way;
                        if (mem_write) begin
                            data_write[hit_way] = 1'b1;
                            set_dirty           = 1'b1;
                        end
                    end else begin
                        way_sel    = victim;
                        state_next = victim_dirty ? WRITEBACK : ALLOCATE;
                    end
                end
            end

            WRITEBACK: begin
                pmem_write    = 1'b1;
                pmem_addr_sel = 1'b1;
                way_sel       = victim;
                if (pmem_resp) begin
                    clr_dirty  = 1'b1;
                    state_next = ALLOCATE;
                end
            end

            ALLOCATE: begin
                pmem_read = 1'b1;
                way_sel   = victim;
                if (pmem_resp) begin
                    data_write[victim] = 1'b1;
                    tag_load[victim]   = 1'b1;
                    datain_sel         = 1'b1;
                    fill               = 1'b1;
                    lru_touch          = 1'b1;
                    lru_way            = victim;
                    state_next         = CHECK;
                end
            end

            default: begin
                state_next = CHECK;
            end
        endcase
    end

    assign data_write0 = data_write[0];
    assign data_write1 = data_write[1];
    assign tag_load0   = tag_load[0];
    assign tag_load1   = tag_load[1];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            // NOTE: metadata is reset (unlike the data/tag arrays) because every line must start invalid.
            valid <= '0;
            dirty <= '0;
            lru   <= '0;
        end else begin
            if (set_dirty) begin
                dirty[hit_way][index] <= 1'b1;
            end
            if (clr_dirty) begin
                dirty[victim][index] <= 1'b0;
            end
            if (fill) begin
                valid[victim][index] <= 1'b1;
                dirty[victim][index] <= 1'b0;
            end
            if (lru_touch) begin
                lru[index] <= ~lru_way;
            end
        end
    end

endmodule
